// File: rtl/sump_cmd_parser.sv
// sump_cmd_parser: assembles SUMP commands from raw UART bytes.
// Short commands (bit7=0) are one byte; long commands (bit7=1) carry a
// 4-byte argument sent LSB first. XON (0x11) / XOFF (0x13) are diverted to
// flow-control pulses instead of being emitted as commands.
// Optional feature macro: LOGIP_CMD_TIMEOUT_EN aborts a partial long command
// after TIMEOUT_CYCLES idle cycles and pulses err_o.
//
// Handshake: rx_stb_i is a one-cycle valid with no ready; every strobed byte
// is consumed in the cycle it is presented. cmd_stb_o, xon_o/xoff_o with
// flow_stb_o, and err_o are one-cycle valid pulses with no backpressure;
// cmd_opcode_o/cmd_data_o/cmd_long_o hold until the next completed command.
module sump_cmd_parser #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk_i,
  input  logic        rst_in,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_stb_i,
  output logic [7:0]  cmd_opcode_o,
  output logic [31:0] cmd_data_o,
  output logic        cmd_long_o,
  output logic        cmd_stb_o,
  output logic        xon_o,
  output logic        xoff_o,
  output logic        flow_stb_o,
  output logic        err_o,
  output logic        dbg_state_o
);

  localparam logic [7:0] XON_BYTE  = 8'h11;
  localparam logic [7:0] XOFF_BYTE = 8'h13;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("sump_cmd_parser: TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ARG  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [7:0]  opcode_q, opcode_d;
  logic [31:0] arg_q, arg_d;
  logic [7:0]  cmd_opcode_q, cmd_opcode_d;
  logic [31:0] cmd_data_q, cmd_data_d;
  logic        cmd_long_q, cmd_long_d;
  logic        cmd_stb_q, cmd_stb_d;
  logic        xon_q, xon_d;
  logic        xoff_q, xoff_d;
  logic        flow_q, flow_d;

`ifdef LOGIP_CMD_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;
`endif

  // Next-state decode: byte classification, argument assembly, output pulses.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    opcode_d     = opcode_q;
    arg_d        = arg_q;
    cmd_opcode_d = cmd_opcode_q;
    cmd_data_d   = cmd_data_q;
    cmd_long_d   = cmd_long_q;
    cmd_stb_d    = 1'b0;
    xon_d        = 1'b0;
    xoff_d       = 1'b0;
    flow_d       = 1'b0;
`ifdef LOGIP_CMD_TIMEOUT_EN
    tmo_d        = '0;
    err_d        = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (rx_stb_i) begin
          if (rx_data_i[7]) begin
            // Long opcode: hold it back until all four argument bytes arrive.
            opcode_d = rx_data_i;
            cnt_d    = 2'd0;
            arg_d    = 32'd0;
            state_d  = ARG;
          end else if (rx_data_i == XON_BYTE) begin
            xon_d  = 1'b1;
            flow_d = 1'b1;
          end else if (rx_data_i == XOFF_BYTE) begin
            xoff_d = 1'b1;
            flow_d = 1'b1;
          end else begin
            cmd_opcode_d = rx_data_i;
            cmd_data_d   = 32'd0;
            cmd_long_d   = 1'b0;
            cmd_stb_d    = 1'b1;
          end
        end
      end

      ARG: begin
        if (rx_stb_i) begin
          // Every byte here is argument data, even 0x00/0x11/0x13.
          case (cnt_q)
            2'd0:    arg_d[7:0]   = rx_data_i;
            2'd1:    arg_d[15:8]  = rx_data_i;
            2'd2:    arg_d[23:16] = rx_data_i;
            default: arg_d[31:24] = rx_data_i;
          endcase
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            cmd_opcode_d = opcode_q;
            cmd_data_d   = {rx_data_i, arg_q[23:0]};
            cmd_long_d   = 1'b1;
            cmd_stb_d    = 1'b1;
            state_d      = IDLE;
          end
        end
`ifdef LOGIP_CMD_TIMEOUT_EN
        else if (tmo_q == TMO_LIMIT) begin
          // Host went quiet mid-argument: drop the partial command.
          state_d = IDLE;
          cnt_d   = 2'd0;
          arg_d   = 32'd0;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end

      default: state_d = IDLE;
    endcase
  end

  // Parser state and registered outputs.
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state_q      <= IDLE;
      cnt_q        <= 2'd0;
      opcode_q     <= 8'd0;
      arg_q        <= 32'd0;
      cmd_opcode_q <= 8'd0;
      cmd_data_q   <= 32'd0;
      cmd_long_q   <= 1'b0;
      cmd_stb_q    <= 1'b0;
      xon_q        <= 1'b0;
      xoff_q       <= 1'b0;
      flow_q       <= 1'b0;
`ifdef LOGIP_CMD_TIMEOUT_EN
      tmo_q        <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      opcode_q     <= opcode_d;
      arg_q        <= arg_d;
      cmd_opcode_q <= cmd_opcode_d;
      cmd_data_q   <= cmd_data_d;
      cmd_long_q   <= cmd_long_d;
      cmd_stb_q    <= cmd_stb_d;
      xon_q        <= xon_d;
      xoff_q       <= xoff_d;
      flow_q       <= flow_d;
`ifdef LOGIP_CMD_TIMEOUT_EN
      tmo_q        <= tmo_d;
      err_q        <= err_d;
`endif
    end
  end

  assign cmd_opcode_o = cmd_opcode_q;
  assign cmd_data_o   = cmd_data_q;
  assign cmd_long_o   = cmd_long_q;
  assign cmd_stb_o    = cmd_stb_q;
  assign xon_o        = xon_q;
  assign xoff_o       = xoff_q;
  assign flow_stb_o   = flow_q;
  assign dbg_state_o  = state_q;
`ifdef LOGIP_CMD_TIMEOUT_EN
  assign err_o        = err_q;
`else
  assign err_o        = 1'b0;
`endif

endmodule

// File: tb/tb_sump_cmd_parser.sv
// Bench for sump_cmd_parser: directed byte streams, a queue-based command
// model compared against the outputs every cycle, and literal spot checks.
// Build with LOGIP_CMD_TIMEOUT_EN defined to also cover the timeout path.
module tb_sump_cmd_parser;

  localparam int TMO = 8;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_stb;
  logic [7:0]  cmd_opcode;
  logic [31:0] cmd_data;
  logic        cmd_long;
  logic        cmd_stb;
  logic        xon;
  logic        xoff;
  logic        flow_stb;
  logic        err;
  logic        dbg_state;

  int checks = 0;
  int errors = 0;
  int stb_cnt = 0;
  int err_cnt = 0;
  int flow_cnt = 0;

  sump_cmd_parser #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk_i        (clk),
    .rst_in       (rst_n),
    .rx_data_i    (rx_data),
    .rx_stb_i     (rx_stb),
    .cmd_opcode_o (cmd_opcode),
    .cmd_data_o   (cmd_data),
    .cmd_long_o   (cmd_long),
    .cmd_stb_o    (cmd_stb),
    .xon_o        (xon),
    .xoff_o       (xoff),
    .flow_stb_o   (flow_stb),
    .err_o        (err),
    .dbg_state_o  (dbg_state)
  );

  // Clock / reset block.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: collects argument bytes in a queue and forms commands
  // from whole byte groups; completed commands go to the scoreboard queue.
  logic [7:0]  m_op;
  logic [31:0] m_data;
  logic        m_long, m_stb, m_xon, m_xoff, m_flow, m_err;
  bit          m_in_long;
  logic [7:0]  m_long_op;
  logic [7:0]  m_bytes[$];
  int          m_idle;
  logic [40:0] exp_q[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_op = 8'h00; m_data = 32'h0; m_long = 1'b0;
      m_stb = 1'b0; m_xon = 1'b0; m_xoff = 1'b0; m_flow = 1'b0; m_err = 1'b0;
      m_in_long = 1'b0; m_bytes.delete(); m_idle = 0; exp_q.delete();
    end else begin
      m_stb = 1'b0; m_xon = 1'b0; m_xoff = 1'b0; m_flow = 1'b0; m_err = 1'b0;
      if (rx_stb) begin
        if (m_in_long) begin
          m_bytes.push_back(rx_data);
          m_idle = 0;
          if (m_bytes.size() == 4) begin
            m_op   = m_long_op;
            m_data = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
            m_long = 1'b1;
            m_stb  = 1'b1;
            m_in_long = 1'b0;
            exp_q.push_back({m_long, m_op, m_data});
          end
        end else if (rx_data == 8'h11) begin
          m_xon = 1'b1; m_flow = 1'b1;
        end else if (rx_data == 8'h13) begin
          m_xoff = 1'b1; m_flow = 1'b1;
        end else if (rx_data >= 8'h80) begin
          m_in_long = 1'b1; m_long_op = rx_data; m_bytes.delete(); m_idle = 0;
        end else begin
          m_op = rx_data; m_data = 32'h0; m_long = 1'b0; m_stb = 1'b1;
          exp_q.push_back({m_long, m_op, m_data});
        end
      end else if (m_in_long) begin
        m_idle++;
`ifdef LOGIP_CMD_TIMEOUT_EN
        if (m_idle == TMO) begin
          m_in_long = 1'b0; m_bytes.delete(); m_err = 1'b1;
        end
`endif
      end
    end
  end

  // Scoreboard / compare process: every cycle out of reset.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("cmd_opcode", {56'h0, cmd_opcode}, {56'h0, m_op});
      chk("cmd_data", {32'h0, cmd_data}, {32'h0, m_data});
      chk("cmd_long", {63'h0, cmd_long}, {63'h0, m_long});
      chk("cmd_stb", {63'h0, cmd_stb}, {63'h0, m_stb});
      chk("xon", {63'h0, xon}, {63'h0, m_xon});
      chk("xoff", {63'h0, xoff}, {63'h0, m_xoff});
      chk("flow_stb", {63'h0, flow_stb}, {63'h0, m_flow});
      chk("err", {63'h0, err}, {63'h0, m_err});
      chk("state", {63'h0, dbg_state}, {63'h0, m_in_long});
      if (cmd_stb) begin
        stb_cnt++;
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_cmd", 64'd1, 64'd0);
        end else begin
          chk("sb_cmd", {23'h0, cmd_long, cmd_opcode, cmd_data}, {23'h0, exp_q.pop_front()});
        end
      end
      if (err) err_cnt++;
      if (flow_stb) flow_cnt++;
    end
  end

  // Driver tasks.
  task automatic send(input logic [7:0] d);
    rx_stb = 1'b1;
    rx_data = d;
    @(posedge clk);
    #1;
    rx_stb = 1'b0;
    rx_data = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
  endtask

  int s0, e0, f0;

  initial begin
    rx_stb = 1'b0;
    rx_data = 8'h00;
    rst_n = 1'b0;
    #2;
    chk("rst_opcode", {56'h0, cmd_opcode}, 64'h0);
    chk("rst_data", {32'h0, cmd_data}, 64'h0);
    chk("rst_stb", {62'h0, cmd_stb, cmd_long}, 64'h0);
    chk("rst_flow", {60'h0, xon, xoff, flow_stb, err}, 64'h0);
    do_reset();

    // Short command.
    send(8'h01);
    chk("short_op", {56'h0, cmd_opcode}, 64'h01);
    chk("short_data", {32'h0, cmd_data}, 64'h0);
    chk("short_stb_long", {62'h0, cmd_stb, cmd_long}, 64'h2);
    idle(1);

    // Long command, consecutive bytes, exactly one strobe.
    s0 = stb_cnt;
    send(8'hC0); send(8'h78); send(8'h56); send(8'h34); send(8'h12);
    chk("long_op", {56'h0, cmd_opcode}, 64'hC0);
    chk("long_data", {32'h0, cmd_data}, 64'h12345678);
    chk("long_stb_long", {62'h0, cmd_stb, cmd_long}, 64'h3);
    idle(2);
    chk("long_one_strobe", stb_cnt - s0, 64'd1);

    // XON then XOFF: no command, outputs unchanged.
    s0 = stb_cnt; f0 = flow_cnt;
    send(8'h11);
    chk("xon_pulse", {61'h0, xon, xoff, flow_stb}, 64'h5);
    send(8'h13);
    chk("xoff_pulse", {61'h0, xon, xoff, flow_stb}, 64'h3);
    chk("flow_op_kept", {56'h0, cmd_opcode}, 64'hC0);
    idle(2);
    chk("flow_no_cmd", stb_cnt - s0, 64'd0);
    chk("flow_pulses", flow_cnt - f0, 64'd2);

    // Resync with zeros: one long 0x80 command then three short 0x00.
    s0 = stb_cnt;
    send(8'h80); send(8'h00); send(8'h00);
    for (int i = 0; i < 5; i++) send(8'h00);
    idle(2);
    chk("resync_strobes", stb_cnt - s0, 64'd4);
    chk("resync_last", {23'h0, cmd_long, cmd_opcode, cmd_data}, 64'h0);

    // Flow-control byte values inside an argument are plain data.
    send(8'h85); send(8'h11); send(8'h13); send(8'h00); send(8'h11);
    chk("arg_flow_bytes", {23'h0, cmd_long, cmd_opcode, cmd_data}, {23'h0, 1'b1, 8'h85, 32'h11001311});
    idle(1);

    // Reset in the middle of an argument.
    send(8'hC1); send(8'hAA);
    rst_n = 1'b0;
    #1;
    chk("midrst_op_data", {24'h0, cmd_opcode, cmd_data}, 64'h0);
    chk("midrst_flags", {59'h0, cmd_stb, cmd_long, xon, xoff, err}, 64'h0);
    chk("midrst_state", {63'h0, dbg_state}, 64'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    send(8'h02);
    chk("postrst_cmd", {22'h0, cmd_stb, cmd_long, cmd_opcode, cmd_data}, {22'h0, 1'b1, 1'b0, 8'h02, 32'h0});
    idle(1);

`ifdef LOGIP_CMD_TIMEOUT_EN
    // Partial long command left idle: one err pulse, no command.
    s0 = stb_cnt; e0 = err_cnt;
    send(8'h81); send(8'h01);
    idle(TMO + 3);
    chk("tmo_err_once", err_cnt - e0, 64'd1);
    chk("tmo_no_cmd", stb_cnt - s0, 64'd0);
    send(8'h02);
    chk("tmo_then_short", {22'h0, cmd_stb, cmd_long, cmd_opcode, cmd_data}, {22'h0, 1'b1, 1'b0, 8'h02, 32'h0});
    idle(1);
    // Byte arriving on the expiry cycle is accepted.
    e0 = err_cnt;
    send(8'h81); send(8'h01);
    idle(TMO - 1);
    send(8'h02); send(8'h03); send(8'h04);
    chk("tmo_edge_cmd", {23'h0, cmd_long, cmd_opcode, cmd_data}, {23'h0, 1'b1, 8'h81, 32'h04030201});
    idle(2);
    chk("tmo_edge_no_err", err_cnt - e0, 64'd0);
`else
    // Without the timeout feature ARG waits indefinitely.
    e0 = err_cnt;
    send(8'h81); send(8'h01);
    idle(3 * TMO);
    send(8'h02); send(8'h03); send(8'h04);
    chk("wait_cmd", {23'h0, cmd_long, cmd_opcode, cmd_data}, {23'h0, 1'b1, 8'h81, 32'h04030201});
    idle(2);
    chk("no_err", err_cnt - e0, 64'd0);
`endif

    chk("sb_drained", exp_q.size(), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sump_cmd_parser.md
Name: sump_cmd_parser

Overview:
- Sits directly upstream of the command-execution stage. It consumes raw bytes from the UART receiver and assembles SUMP-protocol commands.
- Short commands have opcode bit7=0 and are 1 byte long. Long commands have opcode bit7=1 and are 5 bytes long: the opcode followed by 4 argument bytes, sent LSB first.
- Emits one strobed opcode plus a 32-bit argument per complete command.
- XON/XOFF opcodes are diverted to dedicated flow-control pulses that drive the FlowCtr master side.

Parameters:
- TIMEOUT_CYCLES, 1_000_000: idle cycles allowed between argument bytes before a partial long command is aborted. Used only when LOGIP_CMD_TIMEOUT_EN is defined; minimum 2.

Ports:
- clk_i  input  1  system clock
- rst_in  input  1  asynchronous reset, active-low
- rx_data_i  input  8  received byte, valid when rx_stb_i=1
- rx_stb_i  input  1  one-cycle byte-valid pulse; may be asserted on consecutive cycles
- cmd_opcode_o  output  8  opcode of the last completed command
- cmd_data_o  output  32  argument of the last completed command (0 for short commands)
- cmd_long_o  output  1  1 if the last completed command was long
- cmd_stb_o  output  1  one-cycle pulse: command outputs are valid
- xon_o  output  1  one-cycle pulse on receipt of opcode 0x11
- xoff_o  output  1  one-cycle pulse on receipt of opcode 0x13
- flow_stb_o  output  1  one-cycle pulse, asserted together with xon_o or xoff_o
- err_o  output  1  one-cycle pulse when a long command times out (tied 0 without the macro)

Behaviour:
- Reset (rst_in=0, asynchronous): all outputs 0, FSM in IDLE, byte counter 0, argument register 0. The FSM leaves reset on the first clk_i edge after rst_in deasserts.
- FSM states: IDLE, ARG.
- IDLE with rx_stb_i=1:
  - rx_data_i[7]=0 and rx_data_i is neither 0x11 nor 0x13:
    - Next cycle: cmd_opcode_o=rx_data_i, cmd_data_o=0, cmd_long_o=0, cmd_stb_o=1.
    - Stay in IDLE.
  - rx_data_i = 0x11 or 0x13:
    - Next cycle: xon_o or xoff_o pulses, with flow_stb_o=1.
    - cmd_stb_o stays 0 and cmd_* outputs are unchanged.
    - Stay in IDLE.
  - rx_data_i[7]=1:
    - Latch the opcode internally and clear the counter.
    - Go to ARG.
    - No output change yet.
- ARG with rx_stb_i=1:
  - Argument byte k (k=0..3) is written to arg[8k+7:8k].
  - Counter increments.
  - On k=3:
    - Next cycle: cmd_opcode_o=latched opcode, cmd_data_o=assembled argument (including this byte), cmd_long_o=1, cmd_stb_o=1.
    - Return to IDLE.
- Latency: fixed at 1 cycle from the final byte's rx_stb_i to cmd_stb_o, for both short and long commands.
- Back-to-back: a byte accepted in the cycle in which cmd_stb_o is high is processed normally. There are no dead cycles.
- cmd_opcode_o, cmd_data_o and cmd_long_o hold their value until the next completed command.
- In ARG, every byte is treated as argument data, including 0x00, 0x11 and 0x13.
  - Re-synchronisation therefore relies on the SUMP convention: the host sends five 0x00 bytes.
  - After at most 4 argument bytes the parser returns to IDLE. The remaining zeros then decode as short soft-reset commands (opcode 0x00, cmd_stb_o each).
- Unknown short or long opcodes are forwarded unchanged. Decoding is owned downstream.
- rx_stb_i=0: no state change, except for the timeout counter.

Optional Feature:
- Macro: LOGIP_CMD_TIMEOUT_EN.
- When defined:
  - In ARG, a cycle counter is cleared on entry and on every accepted byte, and increments otherwise.
  - When the counter reaches TIMEOUT_CYCLES-1 with no byte that cycle:
    - Return to IDLE and discard the partial argument.
    - Next cycle: err_o=1 for one cycle; cmd_stb_o stays 0.
  - If a byte arrives in the same cycle the counter would expire, the byte wins: it is accepted and the counter is cleared.
  - The counter does not run in IDLE.
- When undefined: no counter logic, ARG waits indefinitely, err_o is constant 0.

Test Plan:
- Reset, then byte 0x01 -> one cycle later cmd_stb_o=1, cmd_opcode_o=0x01, cmd_data_o=0, cmd_long_o=0.
- Bytes C0,78,56,34,12 on consecutive cycles -> one cycle after 0x12: cmd_stb_o=1, opcode 0xC0, data 0x12345678, long=1. Exactly one strobe.
- Bytes 0x11, then 0x13 -> xon_o pulse, then xoff_o pulse, each with flow_stb_o. cmd_stb_o never asserted and cmd_opcode_o unchanged.
- Bytes 80,00,00 then five 0x00 -> one long command completes (opcode 0x80, data 0), then three short 0x00 commands. Total of 4 cmd_stb_o pulses.
- Bytes C1,AA, then assert rst_in=0 mid-ARG -> outputs 0 immediately. Then byte 0x02 -> short command opcode 0x02, no stale argument.
- With LOGIP_CMD_TIMEOUT_EN and TIMEOUT_CYCLES=8:
  - Bytes 81,01, then idle -> err_o pulses once, no cmd_stb_o.
  - A following byte 0x02 decodes as a short command.
  - Repeat with a byte arriving exactly at expiry -> accepted, no err_o.
